// File: rtl/box_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module : box_scan_scheduler
// Raster-order frame-buffer read sequencer over a latched bounding box, run
// for NUM_PASSES passes. Define BOX_SCAN_SUBSAMPLE_EN for stride-2 scanning.
// Rev    : 1.0 - initial release
// ============================================================================
module box_scan_scheduler #(
  parameter int IMAGE_WIDTH  = 1080,
  parameter int IMAGE_HEIGHT = 1920,
  parameter int ADDR_W       = 21,
  parameter int NUM_PASSES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [11:0]       x1,
  input  logic [11:0]       x2,
  input  logic [11:0]       y1,
  input  logic [11:0]       y2,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic [3:0]        pass_idx,
  output logic              pass_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef BOX_SCAN_SUBSAMPLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [12:0]       c_step      = 13'(STEP);
  localparam logic [11:0]       c_step12    = 12'(STEP);
  localparam logic [31:0]       c_width32   = 32'(IMAGE_WIDTH);
  localparam logic [31:0]       c_height32  = 32'(IMAGE_HEIGHT);
  localparam logic [ADDR_W-1:0] c_width     = ADDR_W'(IMAGE_WIDTH);
  localparam logic [ADDR_W-1:0] c_row_step  = ADDR_W'(STEP * IMAGE_WIDTH);
  localparam logic [3:0]        c_last_pass = 4'(NUM_PASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_SCAN     = 3'd2,
    S_PASS_END = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state, w_state_n;
  logic [11:0]       r_x1, r_x2, r_y1, r_y2;
  logic [11:0]       r_x, r_y, w_x_n, w_y_n;
  logic [ADDR_W-1:0] r_row_base, w_row_base_n, r_base0, w_base0_n;
  logic              r_box_bad;
  logic              w_load, w_box_ok, w_accept, w_x_wrap;
  logic [11:0]       w_adv_x, w_adv_y;
  logic [ADDR_W-1:0] w_adv_rb, w_base_mul;
  logic              w_first_last;
  logic              w_rd_valid_n, w_rd_last_n, w_pass_done_n, w_done_n, w_err_n;
  logic [ADDR_W-1:0] w_rd_addr_n;
  logic [3:0]        w_pass_n;

  // True when stepping from pos would pass beyond lim, i.e. pos is the last visited coordinate
  function automatic logic f_at_end(input logic [11:0] pos, input logic [11:0] lim);
    return ({1'b0, pos} + c_step) > {1'b0, lim};
  endfunction

  assign w_load   = (r_state == S_IDLE) && start && !abort;
  assign w_box_ok = (x1 <= x2) && (y1 <= y2) &&
                    (32'(x2) < c_width32) && (32'(y2) < c_height32);
  assign w_accept = rd_valid && rd_ready;

  // Next raster position: incremental row stepping, multiplier only used at job setup
  assign w_x_wrap     = f_at_end(r_x, r_x2);
  assign w_adv_x      = w_x_wrap ? r_x1 : r_x + c_step12;
  assign w_adv_y      = w_x_wrap ? r_y + c_step12 : r_y;
  assign w_adv_rb     = w_x_wrap ? r_row_base + c_row_step : r_row_base;
  assign w_base_mul   = ADDR_W'(r_y1) * c_width;
  assign w_first_last = f_at_end(r_x1, r_x2) && f_at_end(r_y1, r_y2);

  always_comb begin
    w_state_n     = r_state;
    w_x_n         = r_x;
    w_y_n         = r_y;
    w_row_base_n  = r_row_base;
    w_base0_n     = r_base0;
    w_pass_n      = pass_idx;
    w_rd_valid_n  = 1'b0;
    w_rd_addr_n   = rd_addr;
    w_rd_last_n   = 1'b0;
    w_pass_done_n = 1'b0;
    w_done_n      = 1'b0;
    w_err_n       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_n = S_LATCH;
          w_err_n   = !w_box_ok;
        end
      end
      S_LATCH: begin
        if (abort || r_box_bad) begin
          w_state_n = S_IDLE;
        end else begin
          w_state_n    = S_SCAN;
          w_pass_n     = 4'd0;
          w_x_n        = r_x1;
          w_y_n        = r_y1;
          w_row_base_n = w_base_mul;
          w_base0_n    = w_base_mul;
          w_rd_valid_n = 1'b1;
          w_rd_addr_n  = w_base_mul + ADDR_W'(r_x1);
          w_rd_last_n  = w_first_last;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (!w_accept) begin
          w_rd_valid_n = 1'b1;
          w_rd_last_n  = rd_last;
        end else if (rd_last) begin
          w_state_n     = S_PASS_END;
          w_pass_done_n = 1'b1;
        end else begin
          w_x_n        = w_adv_x;
          w_y_n        = w_adv_y;
          w_row_base_n = w_adv_rb;
          w_rd_valid_n = 1'b1;
          w_rd_addr_n  = w_adv_rb + ADDR_W'(w_adv_x);
          w_rd_last_n  = f_at_end(w_adv_x, r_x2) && f_at_end(w_adv_y, r_y2);
        end
      end
      S_PASS_END: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (pass_idx == c_last_pass) begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
        end else begin
          w_state_n    = S_SCAN;
          w_pass_n     = pass_idx + 4'd1;
          w_x_n        = r_x1;
          w_y_n        = r_y1;
          w_row_base_n = r_base0;
          w_rd_valid_n = 1'b1;
          w_rd_addr_n  = r_base0 + ADDR_W'(r_x1);
          w_rd_last_n  = w_first_last;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x1       <= '0;
      r_x2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      r_box_bad  <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_base0    <= '0;
      rd_valid   <= 1'b0;
      rd_addr    <= '0;
      rd_last    <= 1'b0;
      pass_idx   <= 4'd0;
      pass_done  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_x        <= w_x_n;
      r_y        <= w_y_n;
      r_row_base <= w_row_base_n;
      r_base0    <= w_base0_n;
      rd_valid   <= w_rd_valid_n;
      rd_addr    <= w_rd_addr_n;
      rd_last    <= w_rd_last_n;
      pass_idx   <= w_pass_n;
      pass_done  <= w_pass_done_n;
      busy       <= (w_state_n != S_IDLE);
      done       <= w_done_n;
      err        <= w_err_n;
      if (w_load) begin
        r_x1      <= x1;
        r_x2      <= x2;
        r_y1      <= y1;
        r_y2      <= y2;
        r_box_bad <= !w_box_ok;
      end
    end
  end

endmodule
`default_nettype wire
